// File: rtl/seq_alu_pkg.sv
// Shared types and widths for the serial-ALU request dispatcher.
package seq_alu_pkg;

   localparam int DATA_W = 32;
   localparam int CTRL_W = 5;
   localparam int TAG_W  = 4;

   // Dispatcher sequencing: pop a request, pulse start, wait for done, hold result.
   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      WAIT,
      HOLD
   } state_t;

   // One queued request as seen by the FIFO.
   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic              cin;
      logic [CTRL_W-1:0] ctrl;
      logic [TAG_W-1:0]  tag;
   } req_t;

endpackage

// File: rtl/seq_alu_fifo.sv
// Synchronous request FIFO for the dispatcher. No bypass: a word written at
// one edge is visible at the head from the following cycle.
module seq_alu_fifo
   import seq_alu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  req_t                   push_data,
   input  logic                   pop,
   output req_t                   pop_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);

   req_t             mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign full     = (count == (PTR_W+1)'(DEPTH));
   assign empty    = (count == '0);
   assign pop_data = mem[rd_ptr];

   // Storage write; the entry is only read once count says it is valid.
   // NOTE: the data array has no reset -- it is never read before being
   // written, and leaving it out keeps it in plain RAM/flop cells without a reset tree.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/seq_alu_dispatcher.sv
// Front end for the bit-serial adder: queues requests, launches them one at a
// time, edge-detects add_done and returns results over a valid/ready port.
// Optional feature macro: SEQ_ALU_TIMEOUT_EN (abort a request stuck in WAIT
// after TIMEOUT cycles and return it with rsp_err=1).
module seq_alu_dispatcher
   import seq_alu_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 48
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   input  logic        req_cin,
   input  logic [4:0]  req_ctrl,
   input  logic [3:0]  req_tag,
   output logic [31:0] add_a,
   output logic [31:0] add_b,
   output logic        add_cin,
   output logic [4:0]  add_ctrl,
   output logic        add_start,
   input  logic        add_done,
   input  logic [31:0] add_sum,
   input  logic        add_cout,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_sum,
   output logic        rsp_cout,
   output logic [3:0]  rsp_tag,
   output logic        rsp_err
);

   req_t                   fifo_in;
   req_t                   fifo_head;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   fifo_pop;
   logic [$clog2(DEPTH):0] fifo_count;
   logic                   unused_fifo_count;

   state_t           state;
   logic             add_done_q;
   logic [TAG_W-1:0] op_tag;

   assign fifo_in   = '{a: req_a, b: req_b, cin: req_cin, ctrl: req_ctrl, tag: req_tag};
   assign req_ready = !fifo_full;
   assign fifo_pop  = (state == IDLE) && !fifo_empty;

   // Occupancy is exposed by the FIFO but flow control only needs full/empty.
   assign unused_fifo_count = ^fifo_count;

   seq_alu_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (req_valid),
      .push_data (fifo_in),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

`ifdef SEQ_ALU_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] wait_cnt;
`else
   localparam int unused_timeout = TIMEOUT;
   assign rsp_err = 1'b0;
`endif

   // Dispatcher FSM with all adder and response outputs registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         add_start  <= 1'b0;
         add_a      <= '0;
         add_b      <= '0;
         add_cin    <= 1'b0;
         add_ctrl   <= '0;
         op_tag     <= '0;
         add_done_q <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_sum    <= '0;
         rsp_cout   <= 1'b0;
         rsp_tag    <= '0;
`ifdef SEQ_ALU_TIMEOUT_EN
         rsp_err    <= 1'b0;
         wait_cnt   <= '0;
`endif
      end else begin
         // Sampled every cycle so a done level left over from the previous
         // operation is already in add_done_q when WAIT is entered.
         add_done_q <= add_done;
         add_start  <= 1'b0;
         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  add_a     <= fifo_head.a;
                  add_b     <= fifo_head.b;
                  add_cin   <= fifo_head.cin;
                  add_ctrl  <= fifo_head.ctrl;
                  op_tag    <= fifo_head.tag;
                  add_start <= 1'b1;
                  state     <= LAUNCH;
               end
            end
            LAUNCH: begin
               state <= WAIT;
`ifdef SEQ_ALU_TIMEOUT_EN
               wait_cnt <= '0;
`endif
            end
            WAIT: begin
               if (add_done && !add_done_q) begin
                  rsp_sum   <= add_sum;
                  rsp_cout  <= add_cout;
                  rsp_tag   <= op_tag;
                  rsp_valid <= 1'b1;
                  state     <= HOLD;
`ifdef SEQ_ALU_TIMEOUT_EN
                  rsp_err   <= 1'b0;
               end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                  rsp_sum   <= '0;
                  rsp_cout  <= 1'b0;
                  rsp_tag   <= op_tag;
                  rsp_err   <= 1'b1;
                  rsp_valid <= 1'b1;
                  state     <= HOLD;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
`endif
               end
            end
            HOLD: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/seq_alu_dispatcher.md
# seq_alu_dispatcher

Request front end for the bit-serial ALU adder. Buffers operand requests in a small FIFO and launches them one at a time into the serial adder. Detects the adder's completion and returns each result to the consumer over a valid/ready response port. Sits directly upstream of the serial adder and owns all its operand, carry-in and control inputs.

## Interface
Parameters:
- DEPTH, 4: request FIFO entries; power of two, at least 2.
- TIMEOUT, 48: maximum cycles spent in WAIT before a request is aborted (used only with the timeout feature).

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  1  request offered.
- req_ready  out  1  FIFO can accept; equals !full.
- req_a, req_b  in  32  operands.
- req_cin  in  1  carry-in.
- req_ctrl  in  5  ALU control code; passed through unmodified.
- req_tag  in  4  requester tag; returned with the result.
- add_a, add_b  out  32  operands driven to the adder.
- add_cin  out  1  carry-in to the adder.
- add_ctrl  out  5  control code to the adder.
- add_start  out  1  one-cycle launch pulse.
- add_done  in  1  adder completion level.
- add_sum  in  32  adder sum.
- add_cout  in  1  adder carry-out.
- rsp_valid  out  1  result held.
- rsp_ready  in  1  consumer accepts.
- rsp_sum  out  32  result sum.
- rsp_cout  out  1  result carry-out.
- rsp_tag  out  4  tag of the result.
- rsp_err  out  1  request was aborted by timeout.

## Operation
- Push: a request is written when req_valid && req_ready. The FIFO has no bypass; a request pushed in cycle N is visible to the FSM in cycle N+1.
- FSM states: IDLE, LAUNCH, WAIT, HOLD.
- IDLE:
  - If the FIFO is non-empty, pop the head into the operand registers (add_a, add_b, add_cin, add_ctrl, tag) and go to LAUNCH.
  - Otherwise stay in IDLE.
- LAUNCH: assert add_start for exactly one cycle, then go to WAIT.
- WAIT: add_done is sampled into add_done_q every cycle. On the first cycle with add_done=1 and add_done_q=0:
  - capture add_sum, add_cout and tag into the response registers;
  - set rsp_err=0;
  - go to HOLD.
- HOLD: rsp_valid=1. When rsp_ready=1, go to IDLE.
- Operand registers stay stable from pop until the next pop; the adder sees constant inputs for the whole operation.
- Push and pop in the same cycle: both happen and the occupancy count is unchanged. A push when full is blocked by req_ready=0.
- Pointers wrap modulo DEPTH. Occupancy is a counter $clog2(DEPTH)+1 bits wide.
- Reset clears the FIFO and returns the FSM to IDLE; an in-flight request is discarded.
- Reset values:
  - req_ready=1, add_start=0, rsp_valid=0, rsp_err=0;
  - add_a, add_b, add_cin, add_ctrl = 0;
  - rsp_sum, rsp_cout, rsp_tag = 0.

## Timing
- Push to add_start, with an empty FIFO and the FSM in IDLE: 2 cycles (pop in IDLE, pulse in LAUNCH).
- Result timing:
  - add_done rising is sampled at edge E;
  - rsp_valid is high from E+1;
  - rsp_sum/rsp_cout/rsp_tag are stable while rsp_valid=1.
- Response handshake to next launch: at least 2 cycles (HOLD→IDLE, IDLE→LAUNCH).
- add_done already high on entry to WAIT (left over from the previous operation) is not a completion. A 0→1 edge is required.
- At most one request is in flight. Requests complete in FIFO order.

## Configuration
- SEQ_ALU_TIMEOUT_EN defined:
  - a WAIT-cycle counter is cleared on entry to WAIT;
  - if it reaches TIMEOUT without a completion, go to HOLD with rsp_err=1, rsp_sum=0, rsp_cout=0 and the request's tag.
- Undefined: no counter exists, WAIT waits indefinitely, and rsp_err is tied to 0.

## Structure
- Package seq_alu_pkg holds:
  - state enum (IDLE, LAUNCH, WAIT, HOLD);
  - widths DATA_W=32, CTRL_W=5, TAG_W=4;
  - request struct {a, b, cin, ctrl, tag}.
- Sub-module seq_alu_fifo: synchronous FIFO of request structs with push, pop, full, empty and count. Its reset is asynchronous and active-high.

## Test plan
- Single request a=0x0000_0005, b=0x0000_0003, cin=0, tag=1; the model asserts done 34 cycles after start with sum=0x8 -> exactly one add_start pulse, rsp_sum=0x8, rsp_cout=0, rsp_tag=1.
- Overflow request a=0xFFFF_FFFF, b=0x1, cin=0 -> rsp_sum=0x0, rsp_cout=1.
- Five back-to-back pushes with DEPTH=4 while the adder is busy -> req_ready=0 after the fourth queued entry; all five responses return in tag order.
- rsp_ready held low for 10 cycles -> rsp_valid and the response data stay constant; no add_start is issued until acceptance.
- add_done held high from the previous op, then dropped and re-raised -> capture happens only on the re-rise.
- With SEQ_ALU_TIMEOUT_EN and TIMEOUT=48, add_done is never raised -> rsp_valid after 48 WAIT cycles with rsp_err=1, rsp_sum=0. Asserting rst mid-WAIT afterwards returns all outputs to reset values.
